vend_ctrl_param: RTL
====================

// Module: vend_ctrl_param
// PURPOSE
//  Parametrised vending controller, successor to the single-coin cola FSM.
//  - Accepts three coin denominations and vends one item once credit >= PRICE.
//  - Supports cancel/refund and, optionally, change on overpayment.
//  - Sits between the coin-acceptor front end and the dispenser/coin-return drivers.
// PARAMETERS
//  PRICE      3  item price in cents (>=1)
//  CW         4  credit/change width; elaboration error if PRICE-1+COIN3_VAL > 2**CW-1
//  COIN1_VAL  1  value of coin code 2'b01
//  COIN2_VAL  2  value of coin code 2'b10
//  COIN3_VAL  5  value of coin code 2'b11
// PORTS
//  CLK         in   1   clock, rising edge
//  RST         in   1   reset, asynchronous, active-high
//  COIN_IN     in   2   coin code, sampled every cycle; 00 = none; one coin per cycle
//  CANCEL      in   1   request refund of current credit (level, sampled per cycle)
//  TINOUT      out  1   dispense pulse, exactly 1 cycle per vend
//  CHANGE_VLD  out  1   coin-return pulse, 1 cycle
//  CHANGE_AMT  out  CW  return amount; valid only when CHANGE_VLD=1, else 0
//  COIN_REJ    out  1   1-cycle pulse: the coin on COIN_IN this cycle was not accepted
//  CREDIT      out  CW  current accumulated credit
//  BUSY        out  1   1 in VEND/CHANGE/REFUND states
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; credit 0.
//  - All outputs registered (Moore). No combinational input-to-output path.
//  - States: IDLE (credit 0), ACCUM (0 < credit < PRICE), VEND, CHANGE, REFUND.
//  - IDLE/ACCUM, valid coin: credit += coin value.
//    - New credit >= PRICE -> VEND.
//    - New credit < PRICE  -> ACCUM.
//  - VEND: TINOUT=1 for this single cycle; excess = credit - PRICE.
//    - With VEND_CHANGE_EN and excess > 0 -> CHANGE.
//    - Otherwise -> IDLE; credit cleared.
//  - CHANGE: CHANGE_VLD=1, CHANGE_AMT=excess for 1 cycle -> IDLE; credit 0.
//  - ACCUM with CANCEL=1 -> REFUND: CHANGE_VLD=1, CHANGE_AMT=credit for 1 cycle -> IDLE.
//  - CANCEL in IDLE: ignored.
//  - CANCEL and coin in the same ACCUM cycle: cancel wins.
//    - Coin is not credited; COIN_REJ pulses.
//    - Refunds only the prior credit.
//  - Coin in VEND/CHANGE/REFUND: not credited; COIN_REJ pulses next cycle; CANCEL ignored.
//  - Latency: coin completing PRICE on edge N -> TINOUT high in cycle N+1.
//    - Change, when produced, in cycle N+2.
//  - Arithmetic is unsigned CW bits; the parameter check guarantees no overflow.
//  - RST mid-operation: immediate return to IDLE.
//    - Credit is lost; no TINOUT or CHANGE pulse is emitted.
// CONFIGURATION
//  VEND_CHANGE_EN defined: overpayment returned via the CHANGE state.
//  VEND_CHANGE_EN undefined:
//    - Excess is forfeited; VEND -> IDLE always; CHANGE state is not built.
//    - CANCEL refund still uses CHANGE_VLD/CHANGE_AMT.
// STRUCTURE
//  vend_pkg: state encoding (3-bit enum IDLE/ACCUM/VEND/CHANGE/REFUND) and
//    COIN_NONE/COIN1/COIN2/COIN3 code constants.
//  Sub-module vend_coin_decode: COIN_IN -> CW-bit value plus coin_vld.
//    - Purely combinational; parameterised by the COINn_VAL values.
//  Top level: next-state block, state register, registered output block.
// TESTING (PRICE=3, coins 1/2/5, CW=4)
//  1. Three 1-cent coins on consecutive cycles.
//     -> CREDIT 1, 2, 3; TINOUT=1 one cycle after the 3rd coin; no CHANGE_VLD; CREDIT 0.
//  2. One 5-cent coin.
//     -> TINOUT in cycle N+1.
//     -> EN defined: CHANGE_VLD=1, AMT=2 in cycle N+2.
//     -> EN undefined: no CHANGE_VLD.
//  3. 2-cent coin, then CANCEL.
//     -> CHANGE_VLD=1, AMT=2; CREDIT 0; TINOUT stays 0.
//  4. 1-cent coin + CANCEL in the same cycle at credit 1.
//     -> Refund AMT=1; COIN_REJ=1; credit ends at 0.
//  5. 2-cent coin presented during VEND.
//     -> COIN_REJ pulse; CREDIT 0 afterwards; no second TINOUT.
//  6. RST asserted while in ACCUM, credit 2.
//     -> All outputs 0 immediately; no pulses after release; next 3 cents vend normally.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared encodings for the parametrised vending controller.
//   vend_state_t : 3-bit controller state (IDLE/ACCUM/VEND/CHANGE/REFUND)
//   COIN_*       : coin-acceptor codes on COIN_IN
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_REFUND = 3'd4
  } vend_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN1     = 2'b01;
  localparam logic [1:0] COIN2     = 2'b10;
  localparam logic [1:0] COIN3     = 2'b11;

endpackage

// File: rtl/vend_ctrl_param_if.sv
// vend_ctrl_param_if: coin front end <-> vending controller bundle.
//   master : coin acceptor side (drives COIN_IN, CANCEL)
//   slave  : controller side (drives TINOUT, CHANGE_VLD, CHANGE_AMT,
//            COIN_REJ, CREDIT, BUSY)
interface vend_ctrl_param_if #(
  parameter int CW = 4
);
  logic [1:0]    COIN_IN;
  logic          CANCEL;
  logic          TINOUT;
  logic          CHANGE_VLD;
  logic [CW-1:0] CHANGE_AMT;
  logic          COIN_REJ;
  logic [CW-1:0] CREDIT;
  logic          BUSY;

  modport master (
    output COIN_IN, CANCEL,
    input  TINOUT, CHANGE_VLD, CHANGE_AMT, COIN_REJ, CREDIT, BUSY
  );

  modport slave (
    input  COIN_IN, CANCEL,
    output TINOUT, CHANGE_VLD, CHANGE_AMT, COIN_REJ, CREDIT, BUSY
  );
endinterface

// File: rtl/vend_coin_decode.sv
// vend_coin_decode: combinational coin code -> credit value.
//   i_coin : coin code (00 = no coin)
//   o_val  : coin value, CW bits (0 when no coin)
//   o_vld  : a coin is present this cycle
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int CW        = 4,
  parameter int COIN1_VAL = 1,
  parameter int COIN2_VAL = 2,
  parameter int COIN3_VAL = 5
) (
  input  logic [1:0]    i_coin,
  output logic [CW-1:0] o_val,
  output logic          o_vld
);

  always_comb begin
    o_val = '0;
    o_vld = 1'b1;
    case (i_coin)
      COIN1:   o_val = CW'(COIN1_VAL);
      COIN2:   o_val = CW'(COIN2_VAL);
      COIN3:   o_val = CW'(COIN3_VAL);
      default: o_vld = 1'b0;
    endcase
  end

endmodule

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised vending controller.
//   CLK, RST  : clock (rising edge), asynchronous active-high reset
//   bus       : vend_ctrl_param_if.slave (COIN_IN/CANCEL in; TINOUT,
//               CHANGE_VLD, CHANGE_AMT, COIN_REJ, CREDIT, BUSY out)
// Optional feature: define VEND_CHANGE_EN to return overpayment through
// the CHANGE state; otherwise the excess is kept and VEND goes to IDLE.
// All outputs are registered from the next-state decision, so each output
// reflects the state it belongs to in the same cycle (Moore).
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int PRICE     = 3,
  parameter int CW        = 4,
  parameter int COIN1_VAL = 1,
  parameter int COIN2_VAL = 2,
  parameter int COIN3_VAL = 5
) (
  input logic             CLK,
  input logic             RST,
  vend_ctrl_param_if.slave bus
);

  // Worst case credit is PRICE-1 topped up with the largest coin.
  if (PRICE < 1 || (PRICE - 1 + COIN3_VAL) > ((1 << CW) - 1)) begin : g_bad_param
    $error("vend_ctrl_param: PRICE/COIN3_VAL do not fit in CW bits");
  end

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

  vend_state_t   r_state, w_nxt;
  logic [CW-1:0] r_credit, w_credit_nxt;
  logic [CW-1:0] w_coin_val, w_sum, w_amt;
  logic          w_coin_vld, w_rej;
  logic          r_tinout, r_chg_vld, r_rej, r_busy;
  logic [CW-1:0] r_chg_amt;

  vend_coin_decode #(
    .CW(CW), .COIN1_VAL(COIN1_VAL), .COIN2_VAL(COIN2_VAL), .COIN3_VAL(COIN3_VAL)
  ) u_dec (
    .i_coin (bus.COIN_IN),
    .o_val  (w_coin_val),
    .o_vld  (w_coin_vld)
  );

  assign w_sum = r_credit + w_coin_val;

  // Next state, next credit and the payout/reject that the transition emits.
  always_comb begin
    w_nxt        = r_state;
    w_credit_nxt = r_credit;
    w_amt        = '0;
    w_rej        = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (r_state == ST_ACCUM && bus.CANCEL) begin
          // Cancel beats a simultaneous coin: only prior credit is refunded.
          w_nxt        = ST_REFUND;
          w_amt        = r_credit;
          w_credit_nxt = '0;
          w_rej        = w_coin_vld;
        end else if (w_coin_vld) begin
          w_credit_nxt = w_sum;
          w_nxt        = (w_sum >= PRICE_C) ? ST_VEND : ST_ACCUM;
        end
      end
      ST_VEND: begin
        w_rej        = w_coin_vld;
        w_nxt        = ST_IDLE;
        w_credit_nxt = '0;
`ifdef VEND_CHANGE_EN
        if (r_credit > PRICE_C) begin
          w_nxt = ST_CHANGE;
          w_amt = r_credit - PRICE_C;
        end
`endif
      end
      ST_CHANGE, ST_REFUND: begin
        w_rej        = w_coin_vld;
        w_nxt        = ST_IDLE;
        w_credit_nxt = '0;
      end
      default: begin
        w_nxt        = ST_IDLE;
        w_credit_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_credit  <= '0;
      r_tinout  <= 1'b0;
      r_chg_vld <= 1'b0;
      r_chg_amt <= '0;
      r_rej     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_credit  <= w_credit_nxt;
      r_tinout  <= (w_nxt == ST_VEND);
      r_chg_vld <= (w_nxt == ST_CHANGE) || (w_nxt == ST_REFUND);
      r_chg_amt <= w_amt;
      r_rej     <= w_rej;
      r_busy    <= (w_nxt == ST_VEND) || (w_nxt == ST_CHANGE) || (w_nxt == ST_REFUND);
    end
  end

  assign bus.TINOUT     = r_tinout;
  assign bus.CHANGE_VLD = r_chg_vld;
  assign bus.CHANGE_AMT = r_chg_amt;
  assign bus.COIN_REJ   = r_rej;
  assign bus.CREDIT     = r_credit;
  assign bus.BUSY       = r_busy;

endmodule
